// File: rtl/wrp_shff_fifo_ilv.sv
// Ping-pong block buffer between the shuffle network and the AIE stream.
// Each block leaves in natural or row/column-transposed order, with TLAST on its last word.
module wrp_shff_fifo_ilv #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ROWS     = 128,
  parameter int unsigned COLS     = 128,
  parameter int unsigned RD_LAT   = 6,
  parameter int unsigned OF_DEPTH = 16
) (
  input  logic              clk,
  input  logic              arst_i,
  output logic              rdy_o,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              mode_i,
  output logic              ovf_o,
  input  logic              axi_trdy,
  output logic              axi_tvld,
  output logic [DATA_W-1:0] axi_tdat,
  output logic              axi_tlast
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned RB = $clog2(ROWS);
  localparam int unsigned PW = $clog2(OF_DEPTH);
  localparam int unsigned CW = $clog2(OF_DEPTH + RD_LAT + 2) + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  // Write side
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic [1:0]    full_q, full_d;
  logic [1:0]    mode_q, mode_d;
  logic          rdy_q, rdy_d;
  logic          ovf_q, ovf_d;
  // Read side
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  logic [CW-1:0] infl_q, infl_d;
  logic [AW-1:0] rd_addr;
  // RAM read pipeline: stage 0 holds the address, stages 1..RD_LAT carry data
  logic [RD_LAT:0] pv_q;
  logic [RD_LAT:0] pl_q;
  logic [AW:0]     pa_q;
  logic [DATA_W-1:0] pd_q [1:RD_LAT];
  logic [DATA_W-1:0] mem  [2*N];
  // Output FIFO
  logic [DATA_W-1:0]   fmem_q [OF_DEPTH];
  logic [OF_DEPTH-1:0] flast_q;
  logic [PW-1:0]       wptr_q, wptr_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic [CW-1:0]       fcnt_q, fcnt_d;
  logic                tvld_q, tvld_d;

  logic acc, issue, push, pop;

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    full_d    = full_q;
    mode_d    = mode_q;
    ovf_d     = ovf_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    acc       = vld_i & rdy_q;
    push      = pv_q[RD_LAT];
    pop       = tvld_q & axi_trdy;
    issue     = full_q[rd_bank_q] && ((fcnt_q + infl_q) < CW'(OF_DEPTH));
    // Transposed order walks down a column: row = j mod ROWS, col = j div ROWS
    rd_addr   = mode_q[rd_bank_q] ? {rd_cnt_q[RB-1:0], rd_cnt_q[AW-1:RB]} : rd_cnt_q;

    if (vld_i && !rdy_q) ovf_d = 1'b1;

    if (acc) begin
      if (wr_cnt_q == '0) mode_d[wr_bank_q] = mode_i;
      if (wr_cnt_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + AW'(1);
      end
    end

    if (issue) begin
      if (rd_cnt_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_cnt_d          = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + AW'(1);
      end
    end

    rdy_d  = ~(full_d[0] & full_d[1]);
    infl_d = infl_q + CW'(issue) - CW'(push);
    fcnt_d = fcnt_q + CW'(push) - CW'(pop);
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    tvld_d = (fcnt_d != '0);
  end

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
      mode_q    <= '0;
      rdy_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      infl_q    <= '0;
      pv_q      <= '0;
      pl_q      <= '0;
      pa_q      <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      fcnt_q    <= '0;
      tvld_q    <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      mode_q    <= mode_d;
      rdy_q     <= rdy_d;
      ovf_q     <= ovf_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
      infl_q    <= infl_d;
      pv_q      <= {pv_q[RD_LAT-1:0], issue};
      pl_q      <= {pl_q[RD_LAT-1:0], issue && (rd_cnt_q == LAST_IDX)};
      pa_q      <= {rd_bank_q, rd_addr};
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fcnt_q    <= fcnt_d;
      tvld_q    <= tvld_d;
    end
  end

  // Block RAM and its data pipeline need no reset; validity travels in pv_q
  always_ff @(posedge clk) begin
    if (acc) mem[{wr_bank_q, wr_cnt_q}] <= dat_i;
    pd_q[1] <= mem[pa_q];
    for (int i = 2; i <= int'(RD_LAT); i++) pd_q[i] <= pd_q[i-1];
  end

  // FIFO storage is cleared so the head reads zero after reset
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      fmem_q  <= '{default: '0};
      flast_q <= '0;
    end else if (push) begin
      fmem_q[wptr_q]  <= pd_q[RD_LAT];
      flast_q[wptr_q] <= pl_q[RD_LAT];
    end
  end

  assign rdy_o     = rdy_q;
  assign ovf_o     = ovf_q;
  assign axi_tvld  = tvld_q;
  assign axi_tdat  = fmem_q[rptr_q];
  assign axi_tlast = flast_q[rptr_q];

endmodule

// File: tb/tb_wrp_shff_fifo_ilv.sv
// Directed bench for wrp_shff_fifo_ilv with 4x4 blocks; OF_DEPTH=8 keeps the
// output FIFO smaller than one block so a stalled AIE side backs up into the banks.
module tb_wrp_shff_fifo_ilv;

  localparam int unsigned DW  = 16;
  localparam int unsigned OFD = 8;

  logic          clk = 1'b0;
  logic          arst_i;
  logic          rdy_o;
  logic          vld_i;
  logic [DW-1:0] dat_i;
  logic          mode_i;
  logic          ovf_o;
  logic          axi_trdy;
  logic          axi_tvld;
  logic [DW-1:0] axi_tdat;
  logic          axi_tlast;

  wrp_shff_fifo_ilv #(
    .DATA_W(DW), .ROWS(4), .COLS(4), .RD_LAT(6), .OF_DEPTH(OFD)
  ) dut (
    .clk(clk), .arst_i(arst_i), .rdy_o(rdy_o), .vld_i(vld_i), .dat_i(dat_i),
    .mode_i(mode_i), .ovf_o(ovf_o), .axi_trdy(axi_trdy), .axi_tvld(axi_tvld),
    .axi_tdat(axi_tdat), .axi_tlast(axi_tlast)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic acc_flag;
  logic seen_vld;
  int last_acc_cyc;
  int first_vld_cyc;
  logic [DW-1:0] got_d [$];
  logic          got_l [$];
  // Transposed read order of a 4x4 block, by word index within the block
  int tr_ord [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

  // One cycle: drive at the falling edge, record handshakes due at the next rising edge
  task automatic step(input logic v, input logic [DW-1:0] d, input logic m,
                      input logic r, input logic gate);
    @(negedge clk);
    cyc++;
    vld_i    = v & (gate ? rdy_o : 1'b1);
    dat_i    = d;
    mode_i   = m;
    axi_trdy = r;
    acc_flag = vld_i && rdy_o;
    if (acc_flag) last_acc_cyc = cyc;
    if (axi_tvld && !seen_vld) begin
      seen_vld      = 1'b1;
      first_vld_cyc = cyc;
    end
    if (axi_tvld && r) begin
      got_d.push_back(axi_tdat);
      got_l.push_back(axi_tlast);
    end
  endtask

  task automatic clear_obs();
    got_d.delete();
    got_l.delete();
    seen_vld = 1'b0;
  endtask

  task automatic send_block(input int base, input logic m, input logic r);
    int k = 0;
    int guard = 0;
    while (k < 16 && guard < 400) begin
      step(1'b1, DW'(base + k), m, r, 1'b0);
      if (acc_flag) k++;
      guard++;
    end
    checks++;
    if (k != 16) begin
      failures++;
      $display("FAIL send_block_timeout base=%0d accepted=%0d required=16", base, k);
    end
  endtask

  task automatic drain(input int n, input int budget);
    int t = 0;
    while (got_d.size() < n && t < budget) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      t++;
    end
    repeat (10) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (got_d.size() != n) begin
      failures++;
      $display("FAIL drain_count got=%0d required=%0d", got_d.size(), n);
    end
  endtask

  task automatic test_reset();
    arst_i = 1'b1; vld_i = 1'b0; dat_i = '0; mode_i = 1'b0; axi_trdy = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rdy_o !== 1'b0)     begin failures++; $display("FAIL reset_rdy got=%b required=0", rdy_o); end
    checks++; if (axi_tvld !== 1'b0)  begin failures++; $display("FAIL reset_tvld got=%b required=0", axi_tvld); end
    checks++; if (axi_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b required=0", axi_tlast); end
    checks++; if (axi_tdat !== '0)    begin failures++; $display("FAIL reset_tdat got=%0h required=0", axi_tdat); end
    checks++; if (ovf_o !== 1'b0)     begin failures++; $display("FAIL reset_ovf got=%b required=0", ovf_o); end
    arst_i = 1'b0;
    #1;
    checks++; if (rdy_o !== 1'b0) begin failures++; $display("FAIL release_rdy_early got=%b required=0", rdy_o); end
    @(posedge clk); #1;
    checks++; if (rdy_o !== 1'b1) begin failures++; $display("FAIL release_rdy_rise got=%b required=1", rdy_o); end
  endtask

  task automatic test_transpose();
    clear_obs();
    send_block(0, 1'b1, 1'b1);
    drain(16, 100);
    for (int i = 0; i < 16 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== DW'(tr_ord[i])) begin
        failures++; $display("FAIL transpose_dat[%0d] got=%0d required=%0d", i, got_d[i], tr_ord[i]);
      end
      checks++;
      if (got_l[i] !== (i == 15)) begin
        failures++; $display("FAIL transpose_last[%0d] got=%b required=%b", i, got_l[i], (i == 15));
      end
    end
    // Word 15 driven in cycle s is accepted at edge E; state after edge E+8 is seen in cycle s+9
    checks++;
    if (first_vld_cyc - last_acc_cyc != 9) begin
      failures++; $display("FAIL transpose_latency got=%0d required=9", first_vld_cyc - last_acc_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    clear_obs();
    send_block(0, 1'b0, 1'b1);
    send_block(16, 1'b1, 1'b1);
    drain(32, 300);
    for (int i = 0; i < 32 && i < got_d.size(); i++) begin
      e = (i < 16) ? i : 16 + tr_ord[i-16];
      checks++;
      if (got_d[i] !== DW'(e)) begin
        failures++; $display("FAIL b2b_dat[%0d] got=%0d required=%0d", i, got_d[i], e);
      end
      checks++;
      if (got_l[i] !== (i == 15 || i == 31)) begin
        failures++; $display("FAIL b2b_last[%0d] got=%b required=%b", i, got_l[i], (i == 15 || i == 31));
      end
    end
  endtask

  task automatic test_backpressure();
    int c0;
    clear_obs();
    c0 = cyc;
    send_block(200, 1'b0, 1'b0);
    send_block(216, 1'b0, 1'b0);
    checks++;
    if (cyc - c0 != 32) begin
      failures++; $display("FAIL bp_accept_cycles got=%0d required=32", cyc - c0);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (rdy_o !== 1'b0)   begin failures++; $display("FAIL bp_rdy_low got=%b required=0", rdy_o); end
    checks++; if (axi_tvld !== 1'b1) begin failures++; $display("FAIL bp_tvld got=%b required=1", axi_tvld); end
    drain(32, 300);
    for (int i = 0; i < 32 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== DW'(200 + i)) begin
        failures++; $display("FAIL bp_dat[%0d] got=%0d required=%0d", i, got_d[i], 200 + i);
      end
    end
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL bp_ovf got=%b required=0", ovf_o); end
  endtask

  task automatic test_random();
    logic [DW-1:0] blk [16];
    logic [DW-1:0] exp_q [$];
    logic m, r, prev_stall, prev_l;
    logic [DW-1:0] prev_d;
    int k = 0;
    int nblk = 0;
    int t = 0;
    int max_occ = 0;
    int stab_bad = 0;
    clear_obs();
    prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    for (int i = 0; i < 16; i++) blk[i] = DW'($urandom);
    m = 1'($urandom_range(0, 1));
    while ((nblk < 200 || got_d.size() < exp_q.size()) && t < 40000) begin
      r = 1'($urandom_range(0, 1));
      step((nblk < 200) && ($urandom_range(0, 1) == 1), blk[k], m, r, 1'b1);
      t++;
      if (prev_stall && stab_bad == 0) begin
        checks++;
        if (axi_tvld !== 1'b1 || axi_tdat !== prev_d || axi_tlast !== prev_l) begin
          failures++; stab_bad = 1;
          $display("FAIL stall_stable cyc=%0d got=%b/%0h/%b required=1/%0h/%b",
                   cyc, axi_tvld, axi_tdat, axi_tlast, prev_d, prev_l);
        end
      end
      prev_stall = axi_tvld && !r;
      prev_d     = axi_tdat;
      prev_l     = axi_tlast;
      if (int'(dut.fcnt_q) > max_occ) max_occ = int'(dut.fcnt_q);
      if (acc_flag) begin
        k++;
        if (k == 16) begin
          for (int j = 0; j < 16; j++) exp_q.push_back(m ? blk[tr_ord[j]] : blk[j]);
          nblk++;
          k = 0;
          for (int i = 0; i < 16; i++) blk[i] = DW'($urandom);
          m = 1'($urandom_range(0, 1));
        end
      end
    end
    checks++;
    if (got_d.size() != exp_q.size() || nblk != 200) begin
      failures++; $display("FAIL rand_count got=%0d required=%0d blocks=%0d", got_d.size(), exp_q.size(), nblk);
    end
    for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_q[i] || got_l[i] !== ((i % 16) == 15)) begin
        failures++;
        $display("FAIL rand_word[%0d] got=%0h/%b required=%0h/%b", i, got_d[i], got_l[i], exp_q[i], ((i % 16) == 15));
        break;
      end
    end
    checks++;
    if (max_occ > int'(OFD)) begin
      failures++; $display("FAIL rand_occupancy got=%0d required<=%0d", max_occ, OFD);
    end
  endtask

  task automatic test_overflow();
    clear_obs();
    send_block(300, 1'b0, 1'b0);
    send_block(316, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (rdy_o !== 1'b0) begin failures++; $display("FAIL ovf_rdy_low got=%b required=0", rdy_o); end
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL ovf_pre got=%b required=0", ovf_o); end
    step(1'b1, DW'(16'hDEAD), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (ovf_o !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b required=1", ovf_o); end
    repeat (5) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drain(32, 300);
    for (int i = 0; i < 32 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== DW'(300 + i)) begin
        failures++; $display("FAIL ovf_dat[%0d] got=%0h required=%0h", i, got_d[i], 300 + i);
      end
    end
    checks++; if (ovf_o !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b required=1", ovf_o); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int guard = 0;
    clear_obs();
    send_block(50, 1'b0, 1'b1);
    repeat (2) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    while (n < 7 && guard < 50) begin
      step(1'b1, DW'(70 + n), 1'b0, 1'b1, 1'b0);
      if (acc_flag) n++;
      guard++;
    end
    @(negedge clk);
    arst_i = 1'b1; vld_i = 1'b0;
    #1;
    checks++; if (rdy_o !== 1'b0)     begin failures++; $display("FAIL mid_rst_rdy got=%b required=0", rdy_o); end
    checks++; if (axi_tvld !== 1'b0)  begin failures++; $display("FAIL mid_rst_tvld got=%b required=0", axi_tvld); end
    checks++; if (axi_tdat !== '0)    begin failures++; $display("FAIL mid_rst_tdat got=%0h required=0", axi_tdat); end
    checks++; if (axi_tlast !== 1'b0) begin failures++; $display("FAIL mid_rst_tlast got=%b required=0", axi_tlast); end
    checks++; if (ovf_o !== 1'b0)     begin failures++; $display("FAIL mid_rst_ovf got=%b required=0", ovf_o); end
    repeat (2) @(negedge clk);
    arst_i = 1'b0;
    clear_obs();
    send_block(100, 1'b0, 1'b1);
    drain(16, 100);
    for (int i = 0; i < 16 && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== DW'(100 + i) || got_l[i] !== (i == 15)) begin
        failures++;
        $display("FAIL mid_rst_word[%0d] got=%0d/%b required=%0d/%b", i, got_d[i], got_l[i], 100 + i, (i == 15));
      end
    end
  endtask

  initial begin
    test_reset();
    test_transpose();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
